// File: rtl/rca_nibble_sched.sv
// Two-requester adder that shares a single 4-bit ripple stage and adds one nibble per clock.
// Requests are granted round-robin, and each result is held until the consumer accepts it.
module rca_nibble_sched #(
  parameter  int NIB = 4,
  localparam int W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         req1_ready,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_sum,
  output logic         resp_cout,
  output logic         busy
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [CW-1:0]  nib_q, nib_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           id_q, id_d;
  logic           ptr_q, ptr_d;
  logic           resp_valid_q, resp_valid_d;
  logic           busy_q, busy_d;

  logic           gnt0, gnt1;
  logic [3:0]     nib_a, nib_b;
  logic [4:0]     nib_res;

  // ptr_q set means requester 1 wins a tie; ready is suppressed during reset.
  always_comb begin
    gnt0       = req0_valid && (!req1_valid || !ptr_q);
    gnt1       = req1_valid && (!req0_valid ||  ptr_q);
    req0_ready = (state_q == IDLE) && !rst && gnt0;
    req1_ready = (state_q == IDLE) && !rst && gnt1;
  end

  always_comb begin
    nib_a   = a_q[4*nib_q +: 4];
    nib_b   = b_q[4*nib_q +: 4];
    nib_res = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    nib_d        = nib_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    id_d         = id_q;
    ptr_d        = ptr_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          state_d = ADD;
          a_d     = req1_ready ? req1_a   : req0_a;
          b_d     = req1_ready ? req1_b   : req0_b;
          carry_d = req1_ready ? req1_cin : req0_cin;
          id_d    = req1_ready;
          ptr_d   = !req1_ready;
          nib_d   = '0;
        end
      end
      ADD: begin
        sum_d[4*nib_q +: 4] = nib_res[3:0];
        carry_d             = nib_res[4];
        if (nib_q == CW'(NIB - 1)) begin
          cout_d       = nib_res[4];
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end else begin
          nib_d = nib_q + CW'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      nib_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= 1'b0;
      ptr_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      nib_q        <= nib_d;
      carry_q      <= carry_d;
      cout_q       <= cout_d;
      id_q         <= id_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rca_nibble_sched.sv
// Directed self-checking bench for rca_nibble_sched with NIB=4.
// It covers reset, carry handling, round-robin arbitration, backpressure and reset during an add.
module tb_rca_nibble_sched;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         req0_ready, req1_ready;
  logic         resp_valid, resp_ready, resp_id, resp_cout, busy;
  logic [W-1:0] resp_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_accept;

  rca_nibble_sched #(.NIB(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic cin);
    if (idx == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the four add edges that follow an accept; resp_valid must appear on the fourth one only.
  task automatic waitResponse(input string tag);
    for (int k = 0; k < NIB - 1; k++) begin
      tick();
      checkOutput({tag, "_add_valid"}, {31'b0, resp_valid}, 32'd0);
      checkOutput({tag, "_add_ready"}, {30'b0, req1_ready, req0_ready}, 32'd0);
    end
    tick();
    checkOutput({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] sum, input logic cout,
                             input logic id);
    checkOutput({tag, "_sum"},  {16'b0, resp_sum}, {16'b0, sum});
    checkOutput({tag, "_cout"}, {31'b0, resp_cout}, {31'b0, cout});
    checkOutput({tag, "_id"},   {31'b0, resp_id},   {31'b0, id});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    applyStimulus(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Reset held for two edges with requester 0 asking
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
      checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkResult("rst", 16'h0000, 1'b0, 1'b0);
    end
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready0", {31'b0, req0_ready}, 32'd1);
    checkOutput("post_rst_ready1", {31'b0, req1_ready}, 32'd0);

    // Full carry ripple: FFFF + 0001
    tick();
    applyStimulus(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    #1;
    checkOutput("chain_busy", {31'b0, busy}, 32'd1);
    waitResponse("chain");
    checkResult("chain", 16'h0000, 1'b1, 1'b0);
    tick();
    checkOutput("chain_done_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("chain_done_busy", {31'b0, busy}, 32'd0);

    // Carry-in on requester 1: 1234 + 4321 + 1
    applyStimulus(1, 1'b1, 16'h1234, 16'h4321, 1'b1);
    #1;
    checkOutput("cin_ready", {30'b0, req1_ready, req0_ready}, 32'd2);
    tick();
    applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    waitResponse("cin");
    checkResult("cin", 16'h5556, 1'b0, 1'b1);
    tick();
    checkOutput("cin_done_busy", {31'b0, busy}, 32'd0);

    // Backpressure: 8000 + 8001 + 1 held for three stalled cycles
    resp_ready = 1'b0;
    applyStimulus(0, 1'b1, 16'h8000, 16'h8001, 1'b1);
    #1;
    checkOutput("bp_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    waitResponse("bp");
    checkResult("bp", 16'h0002, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 16'h1111, 16'h2222, 1'b0);
    applyStimulus(1, 1'b1, 16'h3333, 16'h4444, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_hold_valid", {31'b0, resp_valid}, 32'd1);
      checkResult("bp_hold", 16'h0002, 1'b1, 1'b0);
      checkOutput("bp_hold_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    end
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    resp_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("bp_release_busy", {31'b0, busy}, 32'd0);

    // Round-robin from reset with both requesters always valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
    applyStimulus(1, 1'b1, 16'h0010, 16'h0020, 1'b1);
    last_accept = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("rr_grant", {30'b0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      if (i > 0) checkOutput("rr_interval", cyc - last_accept, 32'd6);
      last_accept = cyc;
      waitResponse("rr");
      if (i % 2 == 0) checkResult("rr", 16'h0003, 1'b0, 1'b0);
      else            checkResult("rr", 16'h0031, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Reset during nibble 2 of a requester 0 add, then requester 0 must win the tie
    applyStimulus(0, 1'b1, 16'h0F0F, 16'h0101, 1'b0);
    #1;
    checkOutput("mid_ready", {30'b0, req1_ready, req0_ready}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 16'h0F0F, 16'h0101, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(0, 1'b1, 16'h0F0F, 16'h0101, 1'b0);
    applyStimulus(1, 1'b1, 16'h0010, 16'h0020, 1'b1);
    #1;
    checkOutput("mid_rst_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    tick();
    checkOutput("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
    checkResult("mid_rst", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("mid_after_grant", {30'b0, req1_ready, req0_ready}, 32'd1);
    tick();
    applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    waitResponse("mid_after");
    checkResult("mid_after", 16'h1010, 1'b0, 1'b0);
    tick();
    checkOutput("mid_after_busy", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
